// File: rtl/scan_sel_gen.sv
// Scan sequencer: walks a 2-bit select over the enabled positions of a 4-way group,
// holding each position for div+1 cycles. All outputs are registered.
module scan_sel_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [3:0]           mask,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [1:0]           sel,
  output logic                 valid,
  output logic                 tick,
  output logic                 wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;

  logic       active;
  logic       advance;
  logic [1:0] nxt_sel;
  logic [1:0] low_sel;

  // First enabled position after s, searching s+1, s+2, s+3 and finally s itself.
  function automatic logic [1:0] nxt_pos(input logic [1:0] s, input logic [3:0] m);
    logic [1:0] k;
    logic [1:0] r;
    r = s;
    for (int i = 3; i >= 1; i--) begin
      k = s + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  function automatic logic [1:0] low_pos(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign active  = en && (mask != 4'b0000);
  // A position whose enable was dropped mid-dwell is left on the next edge.
  assign advance = (presc_q >= div) || !mask[sel_q];
  assign nxt_sel = nxt_pos(sel_q, mask);
  assign low_sel = low_pos(mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active)  state_d = SCAN;
      SCAN:    if (!active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle values are the defaults; losing en or mask overrides any pending advance.
  always_comb begin
    sel_d   = 2'd0;
    valid_d = 1'b0;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    presc_d = '0;
    case (state_q)
      IDLE: begin
        if (active) begin
          sel_d   = low_sel;
          valid_d = 1'b1;
          tick_d  = 1'b1;
        end
      end
      SCAN: begin
        if (active) begin
          valid_d = 1'b1;
          if (advance) begin
            sel_d  = nxt_sel;
            tick_d = 1'b1;
            wrap_d = (nxt_sel <= sel_q);
          end else begin
            sel_d   = sel_q;
            presc_d = presc_q + DIV_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign sel   = sel_q;
  assign valid = valid_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule
